// File: rtl/ibp_update_queue.sv
// Indirect-branch update queue: buffers committed indirect outcomes and drains
// them one per cycle into the predictor update port, coalescing repeated PCs.
module ibp_update_queue #(
  parameter int DEPTH  = 8,
  parameter int DROP_W = 16
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       resolve_valid_i,
  output logic                       resolve_ready_o,
  input  logic [63:0]                resolve_pc_i,
  input  logic [63:0]                resolve_target_i,
  input  logic                       drain_en_i,
  input  logic                       flush_i,
  output logic                       update_valid_o,
  output logic [63:0]                update_pc_o,
  output logic [63:0]                update_target_o,
  output logic [63:0]                last_target_o,
  output logic [$clog2(DEPTH):0]     count_o,
  output logic [DROP_W-1:0]          drop_cnt_o
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [63:0]       pc_mem  [DEPTH];
  logic [63:0]       tgt_mem [DEPTH];
  logic [AW-1:0]     head_r;
  logic [AW-1:0]     tail_r;
  logic [CW-1:0]     count_r;
  logic [63:0]       last_target_r;
  logic [DROP_W-1:0] drop_cnt_r;

  logic [AW-1:0]     newest_s;
  logic              empty_s;
  logic              ready_s;
  logic              pop_s;
  logic              push_s;
  logic              drop_s;
  logic              coalesce_s;
  logic              alloc_s;
  logic [63:0]       head_pc_s;
  logic [63:0]       head_tgt_s;

  assign newest_s = tail_r - AW'(1);

  // Push/pop/coalesce decisions and head-entry presentation
  always_comb begin
    empty_s    = (count_r == CW'(0));
    ready_s    = (count_r < CW'(DEPTH));
    pop_s      = drain_en_i && !empty_s;
    push_s     = resolve_valid_i && ready_s && !flush_i;
    drop_s     = resolve_valid_i && !ready_s && !flush_i;
    // The newest entry is only being popped when it is also the sole entry.
    coalesce_s = push_s && !empty_s && (pc_mem[newest_s] == resolve_pc_i) &&
                 !(pop_s && (count_r == CW'(1)));
    alloc_s    = push_s && !coalesce_s;
    if (!empty_s) begin
      head_pc_s  = pc_mem[head_r];
      head_tgt_s = tgt_mem[head_r];
    end else begin
      head_pc_s  = 64'd0;
      head_tgt_s = 64'd0;
    end
  end

  // Entry storage: allocate at tail or overwrite the newest target
  always_ff @(posedge clk) begin
    if (alloc_s) begin
      pc_mem[tail_r]  <= resolve_pc_i;
      tgt_mem[tail_r] <= resolve_target_i;
    end else if (coalesce_s) begin
      tgt_mem[newest_s] <= resolve_target_i;
    end
  end

  // Pointers, occupancy and last-target history
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      head_r        <= AW'(0);
      tail_r        <= AW'(0);
      count_r       <= CW'(0);
      last_target_r <= 64'd0;
    end else if (flush_i) begin
      head_r        <= AW'(0);
      tail_r        <= AW'(0);
      count_r       <= CW'(0);
      last_target_r <= 64'd0;
    end else begin
      if (pop_s) begin
        head_r        <= head_r + AW'(1);
        last_target_r <= head_tgt_s;
      end
      if (alloc_s) begin
        tail_r <= tail_r + AW'(1);
      end
      case ({alloc_s, pop_s})
        2'b10:   count_r <= count_r + CW'(1);
        2'b01:   count_r <= count_r - CW'(1);
        default: count_r <= count_r;
      endcase
    end
  end

  // Saturating count of outcomes lost to a full queue; survives flush
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      drop_cnt_r <= DROP_W'(0);
    end else if (drop_s && (drop_cnt_r != {DROP_W{1'b1}})) begin
      drop_cnt_r <= drop_cnt_r + DROP_W'(1);
    end
  end

  assign resolve_ready_o = ready_s;
  assign update_valid_o  = pop_s;
  assign update_pc_o     = head_pc_s;
  assign update_target_o = head_tgt_s;
  assign last_target_o   = last_target_r;
  assign count_o         = count_r;
  assign drop_cnt_o      = drop_cnt_r;

endmodule

// File: tb/tb_ibp_update_queue.sv
// Self-checking bench for ibp_update_queue: directed scenarios followed by
// random traffic, compared against a queue-based reference model.
module tb_ibp_update_queue;
  localparam int DEPTH  = 8;
  localparam int DROP_W = 16;

  logic                   clk;
  logic                   rst;
  logic                   resolve_valid_i;
  logic                   resolve_ready_o;
  logic [63:0]            resolve_pc_i;
  logic [63:0]            resolve_target_i;
  logic                   drain_en_i;
  logic                   flush_i;
  logic                   update_valid_o;
  logic [63:0]            update_pc_o;
  logic [63:0]            update_target_o;
  logic [63:0]            last_target_o;
  logic [$clog2(DEPTH):0] count_o;
  logic [DROP_W-1:0]      drop_cnt_o;

  ibp_update_queue #(.DEPTH(DEPTH), .DROP_W(DROP_W)) dut (
    .clk              (clk),
    .rst              (rst),
    .resolve_valid_i  (resolve_valid_i),
    .resolve_ready_o  (resolve_ready_o),
    .resolve_pc_i     (resolve_pc_i),
    .resolve_target_i (resolve_target_i),
    .drain_en_i       (drain_en_i),
    .flush_i          (flush_i),
    .update_valid_o   (update_valid_o),
    .update_pc_o      (update_pc_o),
    .update_target_o  (update_target_o),
    .last_target_o    (last_target_o),
    .count_o          (count_o),
    .drop_cnt_o       (drop_cnt_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Reference model: an ordered list of pending {pc, target} outcomes.
  logic [63:0] m_pc  [$];
  logic [63:0] m_tgt [$];
  logic [63:0] m_last;
  int          m_drop;
  localparam int DROP_MAX = (1 << DROP_W) - 1;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_pc.delete();
    m_tgt.delete();
    m_last = 64'd0;
    m_drop = 0;
  endtask

  task automatic check_outputs();
    int          n;
    logic        e_valid;
    logic [63:0] e_pc;
    logic [63:0] e_tgt;
    n       = m_pc.size();
    e_valid = drain_en_i && (n != 0);
    e_pc    = (n != 0) ? m_pc[0]  : 64'd0;
    e_tgt   = (n != 0) ? m_tgt[0] : 64'd0;
    chk("update_valid", {63'd0, update_valid_o}, {63'd0, e_valid});
    chk("update_pc", update_pc_o, e_pc);
    chk("update_target", update_target_o, e_tgt);
    chk("resolve_ready", {63'd0, resolve_ready_o}, {63'd0, (n < DEPTH)});
    chk("count", 64'(count_o), 64'(n));
    chk("last_target", last_target_o, m_last);
    chk("drop_cnt", 64'(drop_cnt_o), 64'(m_drop));
  endtask

  // Apply one cycle of inputs (called at posedge+1), check, then advance the model.
  task automatic step(input logic v, input logic [63:0] pc, input logic [63:0] tgt,
                      input logic dr, input logic fl);
    int   n;
    logic pop;
    logic ready;
    resolve_valid_i  = v;
    resolve_pc_i     = pc;
    resolve_target_i = tgt;
    drain_en_i       = dr;
    flush_i          = fl;
    #1;
    check_outputs();
    n     = m_pc.size();
    pop   = dr && (n != 0);
    ready = (n < DEPTH);
    if (fl) begin
      m_pc.delete();
      m_tgt.delete();
      m_last = 64'd0;
    end else begin
      if (v && ready) begin
        if (n >= 1 && m_pc[n-1] == pc && !(pop && n == 1))
          m_tgt[n-1] = tgt;
        else begin
          m_pc.push_back(pc);
          m_tgt.push_back(tgt);
        end
      end
      if (v && !ready && m_drop < DROP_MAX) m_drop++;
      if (pop) begin
        m_last = m_tgt[0];
        void'(m_pc.pop_front());
        void'(m_tgt.pop_front());
      end
    end
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst              = 1'b1;
    resolve_valid_i  = 1'b0;
    resolve_pc_i     = 64'd0;
    resolve_target_i = 64'd0;
    drain_en_i       = 1'b0;
    flush_i          = 1'b0;
    model_reset();
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;

    // Idle after reset with drain enabled
    step(1'b0, 64'd0, 64'd0, 1'b1, 1'b0);
    step(1'b0, 64'd0, 64'd0, 1'b1, 1'b0);

    // Single push then drain: one-cycle latency, last_target follows
    step(1'b1, 64'h1000, 64'h2000, 1'b1, 1'b0);
    step(1'b0, 64'd0, 64'd0, 1'b1, 1'b0);
    step(1'b0, 64'd0, 64'd0, 1'b1, 1'b0);
    chk("last_after_pop", last_target_o, 64'h2000);

    // Fill to DEPTH, then one more is dropped; drain in order
    for (int i = 0; i < DEPTH; i++)
      step(1'b1, 64'h100 + 64'(i) * 64'h10, 64'hA000 + 64'(i), 1'b0, 1'b0);
    step(1'b1, 64'h900, 64'hBEEF, 1'b0, 1'b0);
    chk("drop_after_full", 64'(drop_cnt_o), 64'd1);
    for (int i = 0; i < DEPTH; i++)
      step(1'b0, 64'd0, 64'd0, 1'b1, 1'b0);
    step(1'b0, 64'd0, 64'd0, 1'b1, 1'b0);

    // Coalescing of back-to-back same-PC outcomes
    step(1'b1, 64'h40, 64'hA, 1'b0, 1'b0);
    step(1'b1, 64'h40, 64'hB, 1'b0, 1'b0);
    chk("coalesce_count", 64'(count_o), 64'd1);
    step(1'b0, 64'd0, 64'd0, 1'b1, 1'b0);
    step(1'b0, 64'd0, 64'd0, 1'b1, 1'b0);

    // Steady-state push+pop at count=3 across pointer wrap
    for (int i = 0; i < 3; i++)
      step(1'b1, 64'h3000 + 64'(i), 64'h4000 + 64'(i), 1'b0, 1'b0);
    for (int i = 0; i < 5; i++)
      step(1'b1, 64'h5000 + 64'(i), 64'h6000 + 64'(i), 1'b1, 1'b0);
    chk("steady_count", 64'(count_o), 64'd3);
    for (int i = 0; i < 4; i++)
      step(1'b0, 64'd0, 64'd0, 1'b1, 1'b0);

    // Flush with a simultaneous enqueue at count=4
    for (int i = 0; i < 4; i++)
      step(1'b1, 64'h7000 + 64'(i), 64'h8000 + 64'(i), 1'b0, 1'b0);
    step(1'b1, 64'h7777, 64'h8888, 1'b0, 1'b1);
    chk("flush_count", 64'(count_o), 64'd0);
    chk("flush_last", last_target_o, 64'd0);
    chk("flush_drop_kept", 64'(drop_cnt_o), 64'd1);

    // Random traffic with a small PC pool to exercise coalescing and drops
    for (int i = 0; i < 3000; i++)
      step($urandom_range(0, 99) < 60, 64'($urandom_range(0, 3)) << 2,
           {$urandom, $urandom}, $urandom_range(0, 99) < 45,
           $urandom_range(0, 99) < 2);

    // Asynchronous reset in the middle of a drain
    for (int i = 0; i < 4; i++)
      step(1'b1, 64'hC000 + 64'(i), 64'hD000 + 64'(i), 1'b0, 1'b0);
    resolve_valid_i = 1'b0;
    drain_en_i      = 1'b1;
    #1;
    chk("pre_reset_valid", {63'd0, update_valid_o}, 64'd1);
    rst = 1'b1;
    #1;
    chk("reset_valid", {63'd0, update_valid_o}, 64'd0);
    chk("reset_count", 64'(count_o), 64'd0);
    chk("reset_drop", 64'(drop_cnt_o), 64'd0);
    model_reset();
    @(posedge clk);
    #1;
    rst = 1'b0;
    step(1'b0, 64'd0, 64'd0, 1'b1, 1'b0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
